// File: rtl/mod_mux_pipe.sv
// mod_mux_pipe
//   Pipelined N-way lane selector for the modular datapath. Each accepted beat
//   picks one P_WIDTH-bit lane out of NUM_IN packed lanes. The lane comes either
//   from the external select or from an internal round-robin counter. The result
//   travels through LAT valid-tagged register stages. There is no backpressure:
//   every accepted beat leaves exactly LAT cycles later.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset, clears all state
//   in_valid   an input beat is present this cycle
//   data_in    packed lanes, lane k = data_in[k*P_WIDTH +: P_WIDTH]
//   sel_in     external lane select, used when auto_en = 0
//   auto_en    1 = round-robin select, 0 = sel_in
//   flush      synchronous clear of the stage valids and the round-robin counter
//   S_out      data of the beat leaving the last stage
//   sel_out    lane index actually used for that beat
//   out_valid  S_out/sel_out carry a valid beat
//   err_out    sticky flag: an out-of-range sel_in was accepted
module mod_mux_pipe #(
  parameter int P_WIDTH = 64,
  parameter int NUM_IN  = 4,
  parameter int SEL_W   = 2,
  parameter int LAT     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [NUM_IN*P_WIDTH-1:0]  data_in,
  input  logic [SEL_W-1:0]           sel_in,
  input  logic                       auto_en,
  input  logic                       flush,
  output logic [P_WIDTH-1:0]         S_out,
  output logic [SEL_W-1:0]           sel_out,
  output logic                       out_valid,
  output logic                       err_out
);

  // NUM_IN can equal 2**SEL_W, so the range compare needs one extra bit.
  localparam logic [SEL_W:0]   NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);
  localparam logic [SEL_W-1:0] RR_LAST    = SEL_W'(NUM_IN - 1);

  logic                 accept;
  logic [SEL_W-1:0]     rr_cnt;
  logic [SEL_W-1:0]     eff_sel;
  logic                 sel_ok;
  logic [SEL_W-1:0]     mux_sel;
  logic [P_WIDTH-1:0]   mux_data;

  logic                 stage_valid [LAT];
  logic [P_WIDTH-1:0]   stage_data  [LAT];
  logic [SEL_W-1:0]     stage_sel   [LAT];

  // Flush beats a concurrent input beat. An out-of-range select falls back to
  // lane 0. The reported select is then 0 as well, so sel_out always names
  // the lane that was really delivered.
  always_comb begin
    accept  = in_valid & ~flush;
    eff_sel = auto_en ? rr_cnt : sel_in;
    sel_ok  = {1'b0, eff_sel} < NUM_IN_EXT;
    mux_sel = sel_ok ? eff_sel : '0;
  end

  // The lane mux is written as a compare chain. This keeps every part-select
  // index constant and ignores select codes that name no lane.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (mux_sel == SEL_W'(k)) begin
        mux_data = data_in[k*P_WIDTH +: P_WIDTH];
      end
    end
  end

  // The round-robin counter wraps at NUM_IN-1, not at the top of its range.
  // It only moves on beats that are accepted in auto mode, so idle cycles and
  // manual beats leave the rotation where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_cnt <= '0;
    end else if (flush) begin
      rr_cnt <= '0;
    end else if (accept && auto_en) begin
      rr_cnt <= (rr_cnt == RR_LAST) ? '0 : rr_cnt + 1'b1;
    end
  end

  // The error flag is sticky until reset. Flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_out <= 1'b0;
    end else if (accept && !auto_en && !sel_ok) begin
      err_out <= 1'b1;
    end
  end

  // The valid bits shift every cycle.
  // The data and select registers load only behind a valid beat. On idle
  // cycles the outputs therefore keep showing the last real beat.
  // A flush kills every valid bit and leaves the payload registers alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_valid[i] <= 1'b0;
        stage_data[i]  <= '0;
        stage_sel[i]   <= '0;
      end
    end else begin
      stage_valid[0] <= accept;
      if (accept) begin
        stage_data[0] <= mux_data;
        stage_sel[0]  <= mux_sel;
      end
      for (int i = 1; i < LAT; i++) begin
        stage_valid[i] <= flush ? 1'b0 : stage_valid[i-1];
        if (!flush && stage_valid[i-1]) begin
          stage_data[i] <= stage_data[i-1];
          stage_sel[i]  <= stage_sel[i-1];
        end
      end
    end
  end

  assign S_out     = stage_data[LAT-1];
  assign sel_out   = stage_sel[LAT-1];
  assign out_valid = stage_valid[LAT-1];

endmodule

// File: doc/mod_mux_pipe.md
# mod_mux_pipe

Parametrised, pipelined N-way successor of the team's 2:1 modular-datapath mux. It selects one of NUM_IN P_WIDTH-bit lanes per beat, either from an external select or from an internal round-robin counter, and delivers the result through a LAT-stage valid-tagged pipeline. It sits between the banked coefficient memories and the butterfly units of the NTT/FFT datapath, where lane rotation per beat is required.

## Interface
- P_WIDTH, 64, data width of each lane
- NUM_IN, 4, number of input lanes (2..16)
- SEL_W, 2, select width, ≥ clog2(NUM_IN)
- LAT, 2, pipeline depth in cycles (1..4)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present this cycle
- data_in  input  NUM_IN*P_WIDTH  packed lanes, lane k = bits [k*P_WIDTH +: P_WIDTH]
- sel_in  input  SEL_W  external lane select (manual mode)
- auto_en  input  1  1 = internal round-robin select, 0 = sel_in
- flush  input  1  synchronous pipeline/counter clear
- S_out  output  P_WIDTH  selected lane data
- sel_out  output  SEL_W  lane index actually used for the beat on S_out
- out_valid  output  1  S_out/sel_out carry a valid beat
- err_out  output  1  sticky: an out-of-range sel_in was accepted

## Operation
- Beat accepted when in_valid=1 and flush=0.
- Effective select: auto_en=1 → rr_cnt; auto_en=0 → sel_in.
- Out-of-range sel_in (≥ NUM_IN) in manual mode: lane 0 used, sel_out reports 0, err_out set to 1 on the accepting edge; err_out clears only on rst.
- rr_cnt: SEL_W-bit counter, 0 after reset; increments on each accepted beat while auto_en=1; wraps NUM_IN-1 → 0 (not 2^SEL_W-1). Holds when auto_en=0 or no beat; not reloaded on mode switch.
- Pipeline: LAT stages, each {valid, data, sel}. Stage 0 loads the muxed lane on accept; each later stage copies its predecessor every cycle. Data/sel registers load only when the incoming valid is 1 (hold otherwise); valid bits copy unconditionally.
- No backpressure: every accepted beat emerges exactly LAT cycles later, in order, no drops.
- flush=1: all stage valids and rr_cnt cleared on that edge; concurrent in_valid beat dropped (flush wins); data/sel registers and err_out unchanged.
- rst asserted at any time, including mid-stream: all state cleared immediately; in-flight beats lost.

## Timing
- Reset values: S_out=0, sel_out=0, out_valid=0, err_out=0, rr_cnt=0.
- Latency: beat accepted at edge t appears on S_out/out_valid after edge t+LAT-1 (i.e. LAT register stages; LAT=1 → visible the cycle after in_valid).
- Throughput: one beat per cycle sustained.
- out_valid high exactly one cycle per accepted beat; back-to-back beats give contiguous out_valid.
- When out_valid=0, S_out/sel_out hold last valid beat (don't-care for checking).
- err_out rises in the cycle after the offending accept edge, independent of LAT.
- Flush at edge t: out_valid=0 from edge t through edge t+LAT-1 unless new beats accepted after t.

## Test plan
- Reset/manual: NUM_IN=4, LAT=2, lanes = 0x11,0x22,0x33,0x44; sel_in 0,1,2,3 with in_valid on 4 consecutive cycles → S_out 0x11,0x22,0x33,0x44 with out_valid high on cycles 2..5 after first accept; all outputs 0 during and right after rst.
- Round-robin wrap: NUM_IN=3, SEL_W=2, auto_en=1, 7 contiguous beats → sel_out 0,1,2,0,1,2,0; with idle gaps inserted, sequence unchanged (counter advances only on accepts).
- Out-of-range: NUM_IN=3, manual, sel_in=3 → S_out = lane 0, sel_out=0, err_out=1 and stays 1 after further legal beats until rst.
- Flush collision: 3 beats in flight (LAT=4), flush with in_valid on same edge → no out_valid for any of them nor the colliding beat; next beat after flush with auto_en=1 uses sel 0.
- Async reset mid-stream: assert rst between clock edges with LAT=3 pipeline full → out_valid/S_out/err_out go 0 without a clock edge; after release first accepted beat emerges after exactly LAT cycles.
- Width/depth sweep: P_WIDTH=32, NUM_IN=16, SEL_W=4, LAT=1, random sel_in/data, random in_valid → scoreboard match of every beat, 1-cycle latency.
